mem_access_stage: RTL and testbench

- Memory-access stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a variable-latency data-memory request/acknowledge interface for loads and stores.
- Stalls the upstream pipeline until the access completes.
- Presents load data, ALU result, destination register and write-back controls to MEM/WB, inserting a bubble while stalled.

---
 rtl/mem_access_stage_if.sv | 53 +++++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Bundle of EX/MEM inputs, data-memory req/ack port and MEM/WB outputs for mem_access_stage.
// AlignError exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_access_stage_if;
    logic        MemReadIn;
    logic        MemWriteIn;
    logic        MemToRegIn;
    logic        RegWriteIn;
    logic [31:0] ALUResultIn;
    logic [31:0] WriteDataIn;
    logic [4:0]  DestinationRegIn;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        Stall;
    logic        MemToRegOut;
    logic        RegWriteOut;
    logic [31:0] ReadDataOut;
    logic [31:0] ALUResultOut;
    logic [4:0]  DestinationRegOut;
    logic        MemError;
`ifdef MEM_ALIGN_CHECK_EN
    logic        AlignError;
`endif

    // master: the stage itself
    modport master (
        input  MemReadIn, MemWriteIn, MemToRegIn, RegWriteIn,
        input  ALUResultIn, WriteDataIn, DestinationRegIn,
        input  MemAck, MemRData,
        output MemReq, MemWe, MemAddr, MemWData,
        output Stall, MemToRegOut, RegWriteOut, ReadDataOut,
        output ALUResultOut, DestinationRegOut, MemError
`ifdef MEM_ALIGN_CHECK_EN
        , output AlignError
`endif
    );

    // slave: pipeline registers and data memory around the stage
    modport slave (
        output MemReadIn, MemWriteIn, MemToRegIn, RegWriteIn,
        output ALUResultIn, WriteDataIn, DestinationRegIn,
        output MemAck, MemRData,
        input  MemReq, MemWe, MemAddr, MemWData,
        input  Stall, MemToRegOut, RegWriteOut, ReadDataOut,
        input  ALUResultOut, DestinationRegOut, MemError
`ifdef MEM_ALIGN_CHECK_EN
        , input AlignError
`endif
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues one registered req/ack access per load/store and stalls upstream until done.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are aborted without a request and pulse AlignError.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    mem_access_stage_if.master bus
);
    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          r_req;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_abort;
    logic          w_memop;
    logic          w_misalign;
    logic          w_timeout;
    logic          w_issue;
    logic          w_stall;
    logic          w_in_resp;

    assign w_memop   = bus.MemReadIn | bus.MemWriteIn;
    assign w_timeout = (r_cnt == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align;
    assign w_misalign     = (bus.ALUResultIn[1:0] != 2'b00);
    assign bus.AlignError = r_align;
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // RESP always falls back to IDLE, so the still-held op cannot re-issue.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    w_next_state = w_misalign ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.MemAck || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = 1'b0;
        w_stall   = 1'b0;
        w_in_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue = w_memop & ~w_misalign;
                w_stall = w_memop;
            end
            S_ACCESS: w_stall   = 1'b1;
            S_RESP:   w_in_resp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_abort <= w_memop & w_misalign;
`ifdef MEM_ALIGN_CHECK_EN
                    r_align <= w_memop & w_misalign;
`endif
                    if (w_issue) begin
                        r_req   <= 1'b1;
                        r_we    <= bus.MemWriteIn & ~bus.MemReadIn;
                        r_addr  <= {bus.ALUResultIn[31:2], 2'b00};
                        r_wdata <= bus.WriteDataIn;
                    end
                end
                S_ACCESS: begin
                    // An ack on the final allowed cycle completes normally.
                    if (bus.MemAck) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= bus.MemRData;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
`ifdef MEM_ALIGN_CHECK_EN
                    r_align <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.MemReq            = r_req;
    assign bus.MemWe             = r_we;
    assign bus.MemAddr           = r_addr;
    assign bus.MemWData          = r_wdata;
    assign bus.ReadDataOut       = r_rdata;
    assign bus.MemError          = r_err;
    assign bus.Stall             = w_stall;
    assign bus.MemToRegOut       = bus.MemToRegIn;
    assign bus.ALUResultOut      = bus.ALUResultIn;
    assign bus.DestinationRegOut = bus.DestinationRegIn;
    assign bus.RegWriteOut       = bus.RegWriteIn & ~w_stall & ~(w_in_resp & r_abort);
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops against a transaction-level model.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_stage_if ifc();
    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int n_cmp  = 0;
    int n_fail = 0;

    // transaction-level model state
    logic        m_err;
    logic [31:0] m_rdata;

    // observations of the last op
    int          s_stallc, s_reqc, s_rises, s_first;
    logic [31:0] s_addr, s_wdata, s_rdo, s_alu;
    logic [4:0]  s_dst;
    logic        s_we, s_rw, s_mtr, s_err, s_rwbad, s_done, s_align;

    // Presents one op at posedge+1 in IDLE, plays memory with ack on the lat-th MemReq cycle,
    // observes until the first non-stalled cycle, then removes the op after that cycle.
    task automatic do_op(input logic rd, input logic wr, input logic rw, input logic mtr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] dst, input logic [31:0] rdata, input int lat);
        logic prev_req = 1'b0;
        ifc.MemReadIn = rd; ifc.MemWriteIn = wr; ifc.RegWriteIn = rw; ifc.MemToRegIn = mtr;
        ifc.ALUResultIn = addr; ifc.WriteDataIn = wdata; ifc.DestinationRegIn = dst;
        ifc.MemAck = 1'b0;
        s_stallc = 0; s_reqc = 0; s_rises = 0; s_first = -1; s_rwbad = 1'b0; s_done = 1'b0;
        s_addr = 'x; s_we = 1'bx; s_wdata = 'x; s_align = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (ifc.MemReq) begin
                s_reqc++;
                if (!prev_req) begin
                    s_rises++;
                    if (s_first < 0) begin
                        s_first = c; s_addr = ifc.MemAddr; s_we = ifc.MemWe; s_wdata = ifc.MemWData;
                    end
                end
            end
            prev_req = ifc.MemReq;
            ifc.MemAck   = ifc.MemReq && (s_reqc == lat);
            ifc.MemRData = ifc.MemAck ? rdata : $urandom;
            @(negedge clk);
            if (ifc.Stall) begin
                s_stallc++;
                if (ifc.RegWriteOut) s_rwbad = 1'b1;
            end else begin
                s_rw = ifc.RegWriteOut; s_rdo = ifc.ReadDataOut; s_mtr = ifc.MemToRegOut;
                s_alu = ifc.ALUResultOut; s_dst = ifc.DestinationRegOut; s_err = ifc.MemError;
`ifdef MEM_ALIGN_CHECK_EN
                s_align = ifc.AlignError;
`endif
                s_done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        ifc.MemAck = 1'b0; ifc.MemReadIn = 1'b0; ifc.MemWriteIn = 1'b0; ifc.RegWriteIn = 1'b0;
        n_cmp++;
        if (!s_done) begin n_fail++; $display("FAIL op_completion: Stall never dropped within 40 cycles, required drop"); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.MemReadIn = 0; ifc.MemWriteIn = 0; ifc.RegWriteIn = 0; ifc.MemToRegIn = 0;
        ifc.ALUResultIn = 0; ifc.WriteDataIn = 0; ifc.DestinationRegIn = 0; ifc.MemAck = 0; ifc.MemRData = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_err = 1'b0; m_rdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (ifc.MemReq !== 1'b0)      begin n_fail++; $display("FAIL reset_req: got %b need 0", ifc.MemReq); end
        n_cmp++; if (ifc.MemWe !== 1'b0)       begin n_fail++; $display("FAIL reset_we: got %b need 0", ifc.MemWe); end
        n_cmp++; if (ifc.MemAddr !== 32'h0)    begin n_fail++; $display("FAIL reset_addr: got %h need 0", ifc.MemAddr); end
        n_cmp++; if (ifc.MemWData !== 32'h0)   begin n_fail++; $display("FAIL reset_wdata: got %h need 0", ifc.MemWData); end
        n_cmp++; if (ifc.ReadDataOut !== 32'h0) begin n_fail++; $display("FAIL reset_rdo: got %h need 0", ifc.ReadDataOut); end
        n_cmp++; if (ifc.MemError !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b need 0", ifc.MemError); end
        n_cmp++; if (ifc.Stall !== 1'b0)       begin n_fail++; $display("FAIL reset_stall: got %b need 0", ifc.Stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        do_op(0, 0, 1, 0, 32'h0000_0010, 32'h0, 5'd5, 32'h0, 1);
        n_cmp++; if (s_stallc != 0)      begin n_fail++; $display("FAIL nonmem_stall: got %0d need 0", s_stallc); end
        n_cmp++; if (s_rw !== 1'b1)      begin n_fail++; $display("FAIL nonmem_rw: got %b need 1", s_rw); end
        n_cmp++; if (s_alu !== 32'h10)   begin n_fail++; $display("FAIL nonmem_alu: got %h need 10", s_alu); end
        n_cmp++; if (s_dst !== 5'd5)     begin n_fail++; $display("FAIL nonmem_dst: got %0d need 5", s_dst); end
        n_cmp++; if (s_reqc != 0)        begin n_fail++; $display("FAIL nonmem_req: got %0d need 0", s_reqc); end
    endtask

    task automatic test_load();
        do_op(1, 0, 1, 1, 32'h0000_0104, 32'h0, 5'd7, 32'hDEAD_BEEF, 3);
        m_rdata = 32'hDEAD_BEEF;
        n_cmp++; if (s_addr !== 32'h104)   begin n_fail++; $display("FAIL load_addr: got %h need 104", s_addr); end
        n_cmp++; if (s_we !== 1'b0)        begin n_fail++; $display("FAIL load_we: got %b need 0", s_we); end
        n_cmp++; if (s_stallc != 4)        begin n_fail++; $display("FAIL load_stall: got %0d need 4", s_stallc); end
        n_cmp++; if (s_rwbad !== 1'b0)     begin n_fail++; $display("FAIL load_rw_stalled: got %b need 0", s_rwbad); end
        n_cmp++; if (s_rdo !== m_rdata)    begin n_fail++; $display("FAIL load_rdata: got %h need %h", s_rdo, m_rdata); end
        n_cmp++; if (s_rw !== 1'b1)        begin n_fail++; $display("FAIL load_rw_resp: got %b need 1", s_rw); end
        n_cmp++; if (s_mtr !== 1'b1)       begin n_fail++; $display("FAIL load_mtr: got %b need 1", s_mtr); end
    endtask

    task automatic test_store();
        do_op(0, 1, 0, 0, 32'h0000_0020, 32'h1234_5678, 5'd0, 32'hCAFE_0000, 1);
        n_cmp++; if (s_we !== 1'b1)           begin n_fail++; $display("FAIL store_we: got %b need 1", s_we); end
        n_cmp++; if (s_wdata !== 32'h12345678) begin n_fail++; $display("FAIL store_wdata: got %h need 12345678", s_wdata); end
        n_cmp++; if (s_addr !== 32'h20)       begin n_fail++; $display("FAIL store_addr: got %h need 20", s_addr); end
        n_cmp++; if (s_stallc != 2)           begin n_fail++; $display("FAIL store_stall: got %0d need 2", s_stallc); end
        n_cmp++; if (s_rdo !== m_rdata)       begin n_fail++; $display("FAIL store_rdo: got %h need %h", s_rdo, m_rdata); end
    endtask

    task automatic test_timeout();
        do_op(1, 0, 1, 1, 32'h40, 32'h0, 5'd3, 32'h5555_AAAA, TO);
        m_rdata = 32'h5555_AAAA;
        n_cmp++; if (s_reqc != TO)         begin n_fail++; $display("FAIL ack_last_req: got %0d need %0d", s_reqc, TO); end
        n_cmp++; if (s_err !== 1'b0)       begin n_fail++; $display("FAIL ack_last_err: got %b need 0", s_err); end
        n_cmp++; if (s_rdo !== m_rdata)    begin n_fail++; $display("FAIL ack_last_rdata: got %h need %h", s_rdo, m_rdata); end
        do_op(1, 0, 1, 1, 32'h44, 32'h0, 5'd3, 32'h0, 999);
        m_err = 1'b1;
        n_cmp++; if (s_reqc != TO)         begin n_fail++; $display("FAIL timeout_req: got %0d need %0d", s_reqc, TO); end
        n_cmp++; if (s_stallc != TO + 1)   begin n_fail++; $display("FAIL timeout_stall: got %0d need %0d", s_stallc, TO + 1); end
        n_cmp++; if (s_err !== 1'b1)       begin n_fail++; $display("FAIL timeout_err: got %b need 1", s_err); end
        n_cmp++; if (s_rw !== 1'b0)        begin n_fail++; $display("FAIL timeout_rw: got %b need 0", s_rw); end
        n_cmp++; if (s_rdo !== m_rdata)    begin n_fail++; $display("FAIL timeout_rdo: got %h need %h", s_rdo, m_rdata); end
        do_op(0, 0, 1, 0, 32'h8, 32'h0, 5'd1, 32'h0, 1);
        n_cmp++; if (s_err !== 1'b1)       begin n_fail++; $display("FAIL err_sticky: got %b need 1", s_err); end
        n_cmp++; if (s_rw !== 1'b1)        begin n_fail++; $display("FAIL post_err_rw: got %b need 1", s_rw); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] d = $urandom;
            do_op(1, 0, 1, 1, 32'h100 + 32'(k * 4), 32'h0, 5'd9, d, 2);
            m_rdata = d;
            n_cmp++; if (s_first != 1) begin n_fail++; $display("FAIL b2b_first_req%0d: got cycle %0d need 1", k, s_first); end
            n_cmp++; if (s_rises != 1) begin n_fail++; $display("FAIL b2b_req_count%0d: got %0d need 1", k, s_rises); end
            n_cmp++; if (s_rdo !== d)  begin n_fail++; $display("FAIL b2b_rdata%0d: got %h need %h", k, s_rdo, d); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int          kind = $urandom_range(0, 3);
            int          lat  = $urandom_range(1, 20);
            logic        rd   = (kind == 1) || (kind == 3);
            logic        wr   = (kind == 2) || (kind == 3);
            logic        rw   = 1'($urandom);
            logic        mtr  = 1'($urandom);
            logic [31:0] a    = $urandom;
            logic [31:0] wd   = $urandom;
            logic [31:0] rdt  = $urandom;
            logic [4:0]  dst  = 5'($urandom);
            int          e_req, e_stall;
            logic        ack, e_rw;
`ifdef MEM_ALIGN_CHECK_EN
            a[1:0] = 2'b00;
`endif
            ack = (lat <= TO);
            if (!(rd || wr)) begin
                e_req = 0; e_stall = 0; e_rw = rw;
            end else begin
                e_req = ack ? lat : TO; e_stall = e_req + 1; e_rw = rw & ack;
            end
            do_op(rd, wr, rw, mtr, a, wd, dst, rdt, lat);
            if ((rd || wr) && !ack) m_err = 1'b1;
            if (rd && ack) m_rdata = rdt;
            n_cmp++; if (s_stallc != e_stall) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d need %0d", k, s_stallc, e_stall); end
            n_cmp++; if (s_reqc != e_req)     begin n_fail++; $display("FAIL rnd%0d_req: got %0d need %0d", k, s_reqc, e_req); end
            n_cmp++; if (s_rw !== e_rw)       begin n_fail++; $display("FAIL rnd%0d_rw: got %b need %b", k, s_rw, e_rw); end
            n_cmp++; if (s_rdo !== m_rdata)   begin n_fail++; $display("FAIL rnd%0d_rdo: got %h need %h", k, s_rdo, m_rdata); end
            n_cmp++; if (s_err !== m_err)     begin n_fail++; $display("FAIL rnd%0d_err: got %b need %b", k, s_err, m_err); end
            n_cmp++; if ((s_alu !== a) || (s_dst !== dst) || (s_mtr !== mtr))
                begin n_fail++; $display("FAIL rnd%0d_pass: got %h/%0d/%b need %h/%0d/%b", k, s_alu, s_dst, s_mtr, a, dst, mtr); end
            n_cmp++; if (s_rwbad !== 1'b0)    begin n_fail++; $display("FAIL rnd%0d_rw_stalled: got 1 need 0", k); end
            if (rd || wr) begin
                n_cmp++; if (s_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd%0d_addr: got %h need %h", k, s_addr, {a[31:2], 2'b00}); end
                n_cmp++; if (s_we !== (wr & ~rd))         begin n_fail++; $display("FAIL rnd%0d_we: got %b need %b", k, s_we, wr & ~rd); end
                n_cmp++; if (s_wdata !== wd)              begin n_fail++; $display("FAIL rnd%0d_wdata: got %h need %h", k, s_wdata, wd); end
                n_cmp++; if (s_rises != 1)                begin n_fail++; $display("FAIL rnd%0d_dup_req: got %0d need 1", k, s_rises); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        ifc.MemReadIn = 1; ifc.MemWriteIn = 0; ifc.RegWriteIn = 1; ifc.ALUResultIn = 32'h200; ifc.MemAck = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (ifc.MemReq !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_req: got %b need 1", ifc.MemReq); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_err = 1'b0; m_rdata = 32'h0;
        n_cmp++; if (ifc.MemReq !== 1'b0)   begin n_fail++; $display("FAIL rstmid_req: got %b need 0", ifc.MemReq); end
        n_cmp++; if (ifc.Stall !== 1'b1)    begin n_fail++; $display("FAIL rstmid_stall: got %b need 1", ifc.Stall); end
        n_cmp++; if (ifc.MemError !== m_err) begin n_fail++; $display("FAIL rstmid_err: got %b need 0", ifc.MemError); end
        ifc.MemReadIn = 0; ifc.RegWriteIn = 0;
        @(negedge clk);
        n_cmp++; if (ifc.Stall !== 1'b0)    begin n_fail++; $display("FAIL rstmid_idle_stall: got %b need 0", ifc.Stall); end
        @(posedge clk); #1;
        n_cmp++; if (ifc.MemReq !== 1'b0)   begin n_fail++; $display("FAIL rstmid_no_reissue: got %b need 0", ifc.MemReq); end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        do_op(1, 0, 1, 1, 32'h0000_0003, 32'h0, 5'd4, 32'h0, 1);
        n_cmp++; if (s_reqc != 0)      begin n_fail++; $display("FAIL align_req: got %0d need 0", s_reqc); end
        n_cmp++; if (s_stallc != 1)    begin n_fail++; $display("FAIL align_stall: got %0d need 1", s_stallc); end
        n_cmp++; if (s_align !== 1'b1) begin n_fail++; $display("FAIL align_flag: got %b need 1", s_align); end
        n_cmp++; if (s_rw !== 1'b0)    begin n_fail++; $display("FAIL align_rw: got %b need 0", s_rw); end
        n_cmp++; if (ifc.AlignError !== 1'b0) begin n_fail++; $display("FAIL align_pulse: got %b need 0", ifc.AlignError); end
    endtask
`endif

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
